// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one signed 8x8 start/done multiplier among NUM_REQ requesters.
// Define MULT_SHARE_ARBITER_TIMEOUT_EN to add a WAIT-state watchdog that returns rsp_err after TIMEOUT_CYCLES.
module mult_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW = 2,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_a,
  input  logic [8*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   rsp_valid,
  input  logic [NUM_REQ-1:0]   rsp_ready,
  output logic [15:0]          rsp_product,
  output logic                 rsp_err,
  output logic                 mul_start,
  output logic [7:0]           mul_a,
  output logic [7:0]           mul_b,
  input  logic                 mul_done,
  input  logic [15:0]          mul_product,
  output logic                 busy,
  output logic [IDW-1:0]       grant_id
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state;
  logic [IDW-1:0] last, pick, idx;
  logic found;
  if (NUM_REQ < 2 || NUM_REQ > 8 || IDW != $clog2(NUM_REQ) || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("mult_share_arbiter: illegal parameter combination");
  end
  // Search upward from last+1; iterating farthest-first lets the nearest valid requester win.
  always_comb begin
    pick = '0;
    idx = '0;
    found = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IDW'((int'(last) + k) % NUM_REQ);
      if (req_valid[idx]) begin
        pick = idx;
        found = 1'b1;
      end
    end
  end
  // Acceptance is the IDLE-cycle handshake, so a requester dropping valid first simply loses its turn.
  assign req_ready = (rst_n && state == IDLE && found) ? NUM_REQ'(1) << pick : '0;
  assign busy = state != IDLE;
`ifdef MULT_SHARE_ARBITER_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDW-1:0] wd;
  logic timeout;
  assign timeout = wd == WDW'(TIMEOUT_CYCLES - 1);
`else
  assign rsp_err = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last <= IDW'(NUM_REQ - 1);
      grant_id <= '0;
      mul_a <= '0;
      mul_b <= '0;
      mul_start <= 1'b0;
      rsp_valid <= '0;
      rsp_product <= '0;
`ifdef MULT_SHARE_ARBITER_TIMEOUT_EN
      rsp_err <= 1'b0;
      wd <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (found) begin
          grant_id <= pick;
          mul_a <= req_a[{pick, 3'b000} +: 8];
          mul_b <= req_b[{pick, 3'b000} +: 8];
          mul_start <= 1'b1;
          state <= ISSUE;
        end
        ISSUE: begin
          mul_start <= 1'b0;
          state <= WAIT;
`ifdef MULT_SHARE_ARBITER_TIMEOUT_EN
          wd <= '0;
`endif
        end
        WAIT: if (mul_done) begin
          rsp_product <= mul_product;
          rsp_valid <= NUM_REQ'(1) << grant_id;
          state <= RESP;
`ifdef MULT_SHARE_ARBITER_TIMEOUT_EN
          rsp_err <= 1'b0;
        end else if (timeout) begin
          rsp_product <= '0;
          rsp_err <= 1'b1;
          rsp_valid <= NUM_REQ'(1) << grant_id;
          state <= RESP;
        end else begin
          wd <= wd + 1'b1;
`endif
        end
        RESP: if (rsp_ready[grant_id]) begin
          rsp_valid <= '0;
          last <= grant_id;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: vector table plus corner sequences, with a response scoreboard and a 3-cycle multiplier model.
module tb_mult_share_arbiter;
  localparam int N = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req_valid = '0, req_ready, rsp_valid, rsp_ready = '1;
  logic [8*N-1:0] req_a = '0, req_b = '0;
  logic [15:0] rsp_product, mul_product, prod_q;
  logic rsp_err, mul_start, mul_done, busy;
  logic [7:0] mul_a, mul_b;
  logic [1:0] grant_id;
  logic p0, p1, done_q, stall = 1'b0, spur = 1'b0;
  typedef struct { int id; logic [7:0] a, b, chg; logic [15:0] p; } vec_t;
  typedef struct { int id; logic [15:0] p; logic e; } exp_t;
  vec_t tbl[8];
  exp_t sb[$];
  exp_t mon_e;
  int pass_cnt = 0, total = 0;
  mult_share_arbiter #(.NUM_REQ(N), .IDW(2), .TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_product(rsp_product), .rsp_err(rsp_err), .mul_start(mul_start),
    .mul_a(mul_a), .mul_b(mul_b), .mul_done(mul_done), .mul_product(mul_product),
    .busy(busy), .grant_id(grant_id)
  );
  always #5 clk = ~clk;
  // Multiplier: done arrives 3 cycles after the start cycle, sign bits re-read at completion.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0 <= 1'b0; p1 <= 1'b0; done_q <= 1'b0; prod_q <= '0;
    end else begin
      p0 <= mul_start & ~stall;
      p1 <= p0;
      done_q <= p1;
      if (p1) prod_q <= {{8{mul_a[7]}}, mul_a} * {{8{mul_b[7]}}, mul_b};
    end
  end
  assign mul_done = done_q | spur;
  assign mul_product = prod_q;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask
  always @(negedge clk) begin
    #2;
    if (rst_n && |(rsp_valid & rsp_ready)) begin
      if (sb.size() == 0) chk("unexpected_rsp", 32'(rsp_valid), 0);
      else begin
        mon_e = sb.pop_front();
        chk("rsp_owner", 32'(rsp_valid), 32'(1) << mon_e.id);
        chk("rsp_product", 32'(rsp_product), 32'(mon_e.p));
        chk("rsp_err", 32'(rsp_err), 32'(mon_e.e));
      end
    end
  end
  task automatic op(input int id, input logic [7:0] a, b, chg, input logic [15:0] p, input int lat, input logic e);
    int n;
    req_valid[id] = 1'b1;
    req_a[8*id +: 8] = a;
    req_b[8*id +: 8] = b;
    sb.push_back(exp_t'{id, p, e});
    #1;
    n = 0;
    while (!req_ready[id] && n < 100) begin @(negedge clk); n++; end
    chk("req_ready", 32'(req_ready), 32'(1) << id);
    @(negedge clk);
    req_valid[id] = 1'b0;
    req_a[8*id +: 8] = chg;
    chk("mul_start", 32'(mul_start), 1);
    chk("grant_id", 32'(grant_id), id);
    @(negedge clk);
    chk("mul_start_pulse", 32'(mul_start), 0);
    n = 2;
    while (!rsp_valid[id] && n < 100) begin @(negedge clk); n++; end
    chk("rsp_latency", n, lat);
    chk("mul_a_hold", 32'(mul_a), 32'(a));
    chk("mul_b_hold", 32'(mul_b), 32'(b));
  endtask
  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
    chk("drain", sb.size(), 0);
  endtask
  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    int n, cnt, t_prev, bad;
    int ord[5] = '{0, 1, 2, 3, 0};
    logic [15:0] prods[5] = '{16'hFF80, 16'hFF00, 16'hFE80, 16'hFE00, 16'hFF80};
    tbl[0] = '{0, 8'hFD, 8'h05, 8'hFD, 16'hFFF1};
    tbl[1] = '{1, 8'h07, 8'h03, 8'h7F, 16'h0015};
    tbl[2] = '{2, 8'h80, 8'h80, 8'h80, 16'h4000};
    tbl[3] = '{3, 8'h7F, 8'h7F, 8'h7F, 16'h3F01};
    tbl[4] = '{0, 8'h80, 8'h7F, 8'h80, 16'hC080};
    tbl[5] = '{1, 8'hFF, 8'hFF, 8'hFF, 16'h0001};
    tbl[6] = '{2, 8'h00, 8'h9C, 8'h00, 16'h0000};
    tbl[7] = '{3, 8'h7F, 8'h80, 8'h7F, 16'hC080};
    req_valid = 4'b0001;
    #12;
    chk("reset_ctrl", {busy, rsp_valid, req_ready, mul_start, rsp_err, grant_id, mul_a, mul_b}, 0);
    chk("reset_product", 32'(rsp_product), 0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) op(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].chg, tbl[i].p, 5, 1'b0);
    wait_drain();
    for (int i = 0; i < 4; i++) begin
      req_a[8*i +: 8] = 8'(i + 1);
      req_b[8*i +: 8] = 8'h80;
    end
    req_valid = '1;
    for (int j = 0; j < 5; j++) sb.push_back(exp_t'{ord[j], prods[j], 1'b0});
    #1;
    n = 0; cnt = 0; t_prev = 0;
    while (cnt < 5 && n < 100) begin
      if (req_ready != 0) begin
        chk("rr_grant", 32'(req_ready), 32'(1) << ord[cnt]);
        if (cnt > 0) chk("rr_gap", n - t_prev, 6);
        t_prev = n;
        cnt++;
      end
      if (cnt < 5) begin @(negedge clk); n++; end
    end
    chk("rr_count", cnt, 5);
    @(negedge clk);
    req_valid = '0;
    wait_drain();
    @(negedge clk);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    chk("spur_ignored", {busy, rsp_valid}, 0);
    @(negedge clk);
    chk("spur_ignored2", {busy, rsp_valid}, 0);
    rsp_ready = 4'b1011;
    op(2, 8'h80, 8'h80, 8'h80, 16'h4000, 5, 1'b0);
    req_a[7:0] = 8'h02;
    req_b[7:0] = 8'h03;
    req_valid[0] = 1'b1;
    sb.push_back(exp_t'{0, 16'h0006, 1'b0});
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid !== 4'b0100 || rsp_product !== 16'h4000 || mul_start || req_ready != 0 ||
          mul_a !== 8'h80 || grant_id !== 2'd2) bad++;
    end
    chk("backpressure_hold", bad, 0);
    rsp_ready = '1;
    n = 0;
    while (!req_ready[0] && n < 20) begin @(negedge clk); n++; end
    chk("grant_after_hold", 32'(req_ready), 1);
    @(negedge clk);
    req_valid[0] = 1'b0;
    wait_drain();
`ifdef MULT_SHARE_ARBITER_TIMEOUT_EN
    stall = 1'b1;
    op(1, 8'h12, 8'h34, 8'h12, 16'h0000, 17, 1'b1);
    stall = 1'b0;
    wait_drain();
    op(2, 8'h03, 8'h04, 8'h03, 16'h000C, 5, 1'b0);
    wait_drain();
`endif
    @(negedge clk);
    req_a[31:24] = 8'h11;
    req_b[31:24] = 8'h22;
    req_valid[3] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[3] && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid[3] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("busy_in_wait", 32'(busy), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset", {busy, rsp_valid, req_ready, mul_start, rsp_err, grant_id, mul_a, mul_b}, 0);
    chk("async_reset_product", 32'(rsp_product), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid != 0 || busy) bad++;
    end
    chk("no_stale_rsp", bad, 0);
    req_a[31:24] = 8'h05;
    req_b[31:24] = 8'h06;
    req_valid[3] = 1'b1;
    op(0, 8'h0B, 8'hF6, 8'h0B, 16'hFF92, 5, 1'b0);
    sb.push_back(exp_t'{3, 16'h001E, 1'b0});
    n = 0;
    while (!req_ready[3] && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid[3] = 1'b0;
    wait_drain();
    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Shares one signed 8x8 multiplier unit (start/done interface, 16-bit product) between NUM_REQ independent requesters.
- Round-robin arbitration, one operation in flight at a time.
- Holds operands stable at the multiplier for the whole operation and returns each product to its owner over a valid/ready response handshake.
- Sits between the requesting datapath blocks and the single multiplier instance.

Parameters:
- NUM_REQ, 4, number of requesters; 2..8.
- IDW, 2, width of grant_id; must equal clog2(NUM_REQ).
- TIMEOUT_CYCLES, 15, WAIT-state watchdog limit. Used only with the optional feature.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester operation request
- req_a  in  8*NUM_REQ  signed operand A, requester i at bits [8i+7:8i]
- req_b  in  8*NUM_REQ  signed operand B, same packing
- req_ready  out  NUM_REQ  one-hot accept pulse
- rsp_valid  out  NUM_REQ  one-hot response valid
- rsp_ready  in  NUM_REQ  per-requester response accept
- rsp_product  out  16  signed product, shared by all requesters
- rsp_err  out  1  response is a timeout error
- mul_start  out  1  start pulse to the multiplier
- mul_a  out  8  operand A to the multiplier
- mul_b  out  8  operand B to the multiplier
- mul_done  in  1  multiplier done pulse
- mul_product  in  16  multiplier result
- busy  out  1  an operation is in flight (state != IDLE)
- grant_id  out  IDW  index of the current owner

Behaviour:
Reset (asynchronous, rst_n=0):
- State = IDLE.
- req_ready, rsp_valid, mul_start, rsp_err, busy all 0.
- rsp_product, mul_a, mul_b, grant_id all 0.
- Round-robin pointer last = NUM_REQ-1, so requester 0 has first priority.

FSM states: IDLE, ISSUE, WAIT, RESP.

IDLE:
- If any req_valid bit is set, choose the first set index searching (last+1) mod NUM_REQ upward with wrap.
- Register grant_id = chosen index; register mul_a and mul_b from that requester's operands.
- Assert req_ready[grant] for exactly one cycle. This is the acceptance; the requester may change its operands afterwards.
- Go to ISSUE.

ISSUE:
- mul_start = 1 for exactly this one cycle. Go to WAIT.

WAIT:
- Watchdog counter is cleared on entry.
- On mul_done = 1: capture mul_product into rsp_product, set rsp_err = 0, go to RESP.

RESP:
- rsp_valid[grant] = 1. rsp_product and rsp_err are held until rsp_ready[grant] = 1.
- On that handshake: rsp_valid drops, last = grant, go to IDLE.

Operand stability:
- mul_a and mul_b change only in IDLE. They are stable from ISSUE through RESP, because the multiplier re-reads operand sign bits at completion.

Latency and throughput:
- With the 3-cycle multiplier, req_ready to rsp_valid is 5 cycles.
- Best-case throughput is one operation per 6 cycles (one IDLE cycle between operations).

Boundary conditions:
- mul_done outside WAIT is ignored.
- req_valid on requesters other than the owner is ignored until IDLE. A request is never dropped; it waits.
- A requester that deasserts req_valid before req_ready loses its turn with no side effect.
- rsp_ready on non-owners is ignored.
- The same requester cannot be granted twice in a row while any other requester is valid.
- Reset mid-operation aborts immediately: no response is produced, and the in-flight multiplier result is ignored after reset. The multiplier must be reset by the same rst_n.
- grant_id is held stable from IDLE acceptance through RESP.

Optional Feature:
MULT_SHARE_ARBITER_TIMEOUT_EN
- Defined:
  - A counter runs in WAIT.
  - If mul_done has not arrived after TIMEOUT_CYCLES cycles in WAIT, go to RESP with rsp_product = 0 and rsp_err = 1.
  - A mul_done arriving on that exact cycle takes precedence: normal result, rsp_err = 0.
  - A late mul_done after a timeout is ignored, since it arrives outside WAIT.
- Undefined:
  - No counter logic is built; rsp_err is tied to 0.
  - WAIT waits indefinitely for mul_done.

Test Plan:
1. Single request: req 0 with a=0xFD(-3), b=0x05 -> req_ready[0] pulses once; mul_start exactly 1 cycle; rsp_valid[0] 5 cycles after req_ready; rsp_product=0xFFF1.
2. All four requesters valid continuously, a=i+1, b=0x80(-128) -> grants in order 0,1,2,3,0; products 0xFF80, 0xFF00, 0xFE80, 0xFE00; no double grant.
3. Backpressure: rsp_ready[2] low for 10 cycles, a=0x80, b=0x80 -> rsp_valid[2] and rsp_product=0x4000 held stable; no new req_ready or mul_start until the handshake.
4. Operand change after acceptance: req 1 changes req_a from 0x07 to 0x7F after req_ready (b=0x03) -> mul_a stays 0x07; product 0x0015.
5. Reset asserted in WAIT -> all outputs 0 asynchronously; after release, the next request is granted to requester 0 and completes normally; no stale rsp_valid.
6. With MULT_SHARE_ARBITER_TIMEOUT_EN, mul_done held 0 -> after 15 WAIT cycles, rsp_valid with rsp_product=0x0000 and rsp_err=1; a following normal op has rsp_err=0.
